// File: rtl/hash_msg_loader.sv
// hash_msg_loader: packs a byte stream into padded message blocks
// and hands each block to the hash core, one at a time.
module hash_msg_loader #(
  parameter int          BLOCK_BYTES = 4,
  parameter logic [7:0]  PAD_BYTE    = 8'h80,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       blk_data [0:BLOCK_BYTES-1],
  output logic             blk_start,
  output logic             blk_last,
  input  logic             core_done,
  output logic             msg_done,
  output logic [CNT_W-1:0] blk_count
);

  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             pend_pad;
  logic             done_q;
  logic             new_msg;
  logic             accept;
  logic             comp;

  assign in_ready  = (state == S_FILL);
  assign blk_start = (state == S_ISSUE);
  assign accept    = in_valid & in_ready;
  assign comp      = core_done & ~done_q;

  // Edge detector on the core's done level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= core_done;
  end

  // Fill / issue / wait sequencing with padding and block counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      idx       <= '0;
      pend_pad  <= 1'b0;
      new_msg   <= 1'b1;
      blk_last  <= 1'b0;
      msg_done  <= 1'b0;
      blk_count <= '0;
      for (int i = 0; i < BLOCK_BYTES; i++)
        blk_data[i] <= 8'h00;
    end else begin
      msg_done <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept) begin
            blk_data[idx] <= in_data;
            new_msg <= 1'b0;
            if (new_msg) blk_count <= '0;
            if (in_last) begin
              state <= S_ISSUE;
              idx   <= '0;
              if (idx == LAST_IDX) begin
                blk_last <= 1'b0;
                pend_pad <= 1'b1;
              end else begin
                blk_last <= 1'b1;
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                  if (i == int'(idx) + 1)
                    blk_data[i] <= PAD_BYTE;
                  else if (i > int'(idx) + 1)
                    blk_data[i] <= 8'h00;
                end
              end
            end else if (idx == LAST_IDX) begin
              state    <= S_ISSUE;
              blk_last <= 1'b0;
              idx      <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (blk_count != '1)
            blk_count <= blk_count + CNT_W'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (comp) begin
            if (pend_pad) begin
              for (int i = 0; i < BLOCK_BYTES; i++)
                blk_data[i] <= (i == 0) ? PAD_BYTE : 8'h00;
              blk_last <= 1'b1;
              pend_pad <= 1'b0;
              state    <= S_ISSUE;
            end else if (blk_last) begin
              msg_done <= 1'b1;
              blk_last <= 1'b0;
              new_msg  <= 1'b1;
              state    <= S_FILL;
            end else begin
              state <= S_FILL;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_loader.sv
// tb_hash_msg_loader: directed checks of packing, padding,
// done-edge handling and asynchronous reset.
module tb_hash_msg_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  blk_data [0:3];
  logic        blk_start;
  logic        blk_last;
  logic        core_done;
  logic        msg_done;
  logic [15:0] blk_count;

  int vecs;
  int errs;

  hash_msg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_start (blk_start),
    .blk_last  (blk_last),
    .core_done (core_done),
    .msg_done  (msg_done),
    .blk_count (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] blk32();
    return {blk_data[0], blk_data[1], blk_data[2], blk_data[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Rising edge of core_done; returns at the negedge after completion.
  task automatic pulse_done();
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  // Called in the ISSUE cycle; also checks the first WAIT cycle.
  task automatic expect_issue(input string tag, input logic [31:0] d,
                              input logic last);
    chk({tag, "_start"}, 32'(blk_start), 32'h1);
    chk({tag, "_data"}, blk32(), d);
    chk({tag, "_last"}, 32'(blk_last), 32'(last));
    @(negedge clk);
    chk({tag, "_wstart"}, 32'(blk_start), 32'h0);
    chk({tag, "_wready"}, 32'(in_ready), 32'h0);
  endtask

  initial begin
    logic [31:0] held;
    vecs      = 0;
    errs      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    core_done = 1'b0;

    #12;
    chk("rst_data", blk32(), 32'h0);
    chk("rst_start", 32'(blk_start), 32'h0);
    chk("rst_last", 32'(blk_last), 32'h0);
    chk("rst_msgdone", 32'(msg_done), 32'h0);
    chk("rst_count", 32'(blk_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'h1);

    // 3-byte message
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    expect_issue("m3", 32'h11223380, 1'b1);
    chk("m3_wcount", 32'(blk_count), 32'd1);
    pulse_done();
    chk("m3_msgdone", 32'(msg_done), 32'h1);
    chk("m3_count", 32'(blk_count), 32'd1);
    chk("m3_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("m3_msgdone_off", 32'(msg_done), 32'h0);

    // 4-byte message: needs an extra pad block
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    expect_issue("m4a", 32'hA0A1A2A3, 1'b0);
    chk("m4a_count", 32'(blk_count), 32'd1);
    pulse_done();
    chk("m4_nomsg", 32'(msg_done), 32'h0);
    expect_issue("m4b", 32'h80000000, 1'b1);
    pulse_done();
    chk("m4_msgdone", 32'(msg_done), 32'h1);
    chk("m4_count", 32'(blk_count), 32'd2);

    // 9-byte message, with in_valid held during WAIT
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    expect_issue("m9a", 32'h01020304, 1'b0);
    held = blk32();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'hE0 + 8'(k);
      in_last = k[0];
      @(negedge clk);
      chk("m9_hold_ready", 32'(in_ready), 32'h0);
      chk("m9_hold_data", blk32(), held);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    pulse_done();
    chk("m9a_nomsg", 32'(msg_done), 32'h0);
    chk("m9a_ready", 32'(in_ready), 32'h1);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    expect_issue("m9b", 32'h05060708, 1'b0);
    chk("m9b_count", 32'(blk_count), 32'd2);
    pulse_done();
    send(8'h09, 1'b1);
    expect_issue("m9c", 32'h09800000, 1'b1);
    pulse_done();
    chk("m9_msgdone", 32'(msg_done), 32'h1);
    chk("m9_count", 32'(blk_count), 32'd3);

    // core_done already high on WAIT entry
    core_done = 1'b1;
    send(8'h77, 1'b1);
    expect_issue("stk", 32'h77800000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stk_wait", 32'(in_ready), 32'h0);
      chk("stk_nomsg", 32'(msg_done), 32'h0);
    end
    core_done = 1'b0;
    @(negedge clk);
    chk("stk_low_wait", 32'(in_ready), 32'h0);
    pulse_done();
    chk("stk_msgdone", 32'(msg_done), 32'h1);
    chk("stk_count", 32'(blk_count), 32'd1);

    // Async reset mid-WAIT of a 2-block message
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b1);
    expect_issue("ar", 32'hC0C1C2C3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_data", blk32(), 32'h0);
    chk("ar_start", 32'(blk_start), 32'h0);
    chk("ar_last", 32'(blk_last), 32'h0);
    chk("ar_msgdone", 32'(msg_done), 32'h0);
    chk("ar_count", 32'(blk_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_ready", 32'(in_ready), 32'h1);
    send(8'h5A, 1'b1);
    expect_issue("m1", 32'h5A800000, 1'b1);
    pulse_done();
    chk("m1_msgdone", 32'(msg_done), 32'h1);
    chk("m1_count", 32'(blk_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hash_msg_loader.md
Name: hash_msg_loader

Overview:
- Upstream feeder for hash_function.
- Accepts a byte stream (valid/ready plus last), packs bytes into 4-byte message blocks and applies padding.
- Drives each block as m[0:3] together with a start pulse, then waits for the core's completion before accepting more bytes.

Parameters:
- BLOCK_BYTES, 4: bytes per block; must match the core's m[0:3].
- PAD_BYTE, 8'h80: first padding byte; remaining pad bytes are 8'h00.
- CNT_W, 16: width of blk_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_last  in  1  marks final byte of message; qualified by in_valid
- in_ready  out  1  loader can accept a byte this cycle
- blk_data  out  8x4 (unpacked [0:3])  block to core m[0:3]; byte 0 = first received
- blk_start  out  1  one-cycle start pulse to core
- blk_last  out  1  current block is the message's final (padded) block
- core_done  in  1  core done level; rising edge = block finished
- msg_done  out  1  one-cycle pulse when the final block completes
- blk_count  out  CNT_W  blocks issued for the current message

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk), effective immediately, including mid-block or mid-WAIT:
  - state=FILL, idx=0, pend_pad=0.
  - blk_data all 8'h00.
  - blk_start=0, blk_last=0, msg_done=0, blk_count=0.
  - done_q=0.
  - in_ready=1 from the first cycle after reset is released.
- in_ready=1 only in FILL. A byte is accepted when in_valid & in_ready. in_valid/in_data are ignored in other states.
- FILL:
  - On accept, blk_data[idx] <= in_data.
  - If this is the first byte of a message (idx=0 and the previous message ended, or after reset), blk_count <= 0 in the same cycle.
  - Accept, not last, idx<3: idx <= idx+1.
  - Accept, not last, idx==3: go to ISSUE, blk_last <= 0, idx <= 0.
  - Accept, last, idx<3: in the same cycle blk_data[idx+1] <= PAD_BYTE and higher bytes <= 8'h00. Go to ISSUE, blk_last <= 1.
  - Accept, last, idx==3: go to ISSUE, blk_last <= 0, pend_pad <= 1.
- ISSUE, one cycle:
  - blk_start=1.
  - blk_count <= blk_count+1, saturating at all-ones.
  - Go to WAIT.
- Latency: blk_start is asserted in the cycle after the byte that completes the block is accepted.
- WAIT:
  - blk_data and blk_last are held stable until exit.
  - Completion = core_done & ~done_q, where done_q is core_done registered every cycle.
  - On completion with pend_pad=1: blk_data <= {PAD_BYTE, 00, 00, 00}, blk_last <= 1, pend_pad <= 0, go to ISSUE.
  - On completion with blk_last=1: msg_done pulses for 1 cycle, blk_last <= 0, go to FILL. The next accepted byte starts a new message.
  - On completion otherwise: go to FILL.
- Boundary rules:
  - A core_done already high on WAIT entry, with no rising edge, does not count. The core's sticky done therefore needs an edge. The loader never issues blk_start while in WAIT.
  - An empty message is not supported: in_last always accompanies a real byte.
  - blk_start and msg_done are never high in the same cycle.
- Width and arithmetic:
  - idx is 2 bits and wraps only via the explicit reset to 0.
  - blk_count saturates and does not wrap.

Test Plan:
- 3-byte message 11,22,33 (last on 33) -> one blk_start with blk_data={11,22,33,80}, blk_last=1. After a core_done edge: msg_done pulse, blk_count=1.
- 4-byte message A0..A3 -> first block {A0,A1,A2,A3} with blk_last=0. After a done edge, a second block {80,00,00,00} with blk_last=1. msg_done follows the second done edge; blk_count=2.
- 9-byte message 01..09 -> blocks {01..04}, {05..08}, {09,80,00,00}. in_ready=0 throughout each WAIT; blk_count=3.
- Hold in_valid=1 during WAIT and toggle in_data -> no byte is consumed, and blk_data does not change until completion.
- core_done held high from before WAIT entry -> no completion until it drops and rises again.
- Assert rst_n=0 mid-WAIT of a 2-block message -> all outputs return to reset values asynchronously. A following 1-byte message 5A -> block {5A,80,00,00} with blk_count=1.
